// File: rtl/class_hvec_search.sv
// Associative search of a buffered query hypervector against the class memory; returns the min-Hamming class.
// Optional CLASS_HVEC_SEARCH_EARLY_EXIT_EN abandons a class once its partial distance cannot beat the best.
module class_hvec_search #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int N_CLASSES          = 8,
    parameter int N_FRAMES           = 3,
    parameter int CLASS_ID_W         = 3,
    parameter int FRAME_IDX_W        = 2,
    parameter int DIST_W             = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          query_valid,
    output logic                          query_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0] query_data,
    output logic [CLASS_ID_W-1:0]         frame_id,
    output logic [FRAME_IDX_W-1:0]        frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [CLASS_ID_W-1:0]         result_class,
    output logic [DIST_W-1:0]             result_dist,
    output logic                          busy
);

    typedef enum logic [1:0] {S_LOAD, S_SEARCH, S_DONE} state_t;

    localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(N_FRAMES - 1);
    localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(N_CLASSES - 1);

    state_t                          state_q, state_d;
    logic [DI_PARALLEL_W_BITS-1:0]   qbuf_q [N_FRAMES];
    logic [DI_PARALLEL_W_BITS-1:0]   qbuf_d [N_FRAMES];
    logic [FRAME_IDX_W-1:0]          load_cnt_q, load_cnt_d;
    logic [FRAME_IDX_W-1:0]          frm_q, frm_d;
    logic [CLASS_ID_W-1:0]           cls_q, cls_d;
    logic [CLASS_ID_W-1:0]           best_class_q, best_class_d;
    logic [DIST_W-1:0]               acc_q, acc_d;
    logic [DIST_W-1:0]               best_dist_q, best_dist_d;

    logic [DI_PARALLEL_W_BITS-1:0]   cur_q;
    logic [DI_PARALLEL_W_BITS-1:0]   diff;
    logic [DIST_W-1:0]               pc;
    logic [DIST_W-1:0]               sum;
    logic                            last_frm;
    logic                            end_class;

    always_comb begin
        cur_q = '0;
        for (int i = 0; i < N_FRAMES; i++) begin
            if (frm_q == FRAME_IDX_W'(i)) cur_q = qbuf_q[i];
        end
        diff = cur_q ^ class_vec_in;
        pc   = '0;
        for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
            pc = pc + DIST_W'(diff[i]);
        end
        sum      = acc_q + pc;
        last_frm = (frm_q == LAST_FRM);
`ifdef CLASS_HVEC_SEARCH_EARLY_EXIT_EN
        end_class = last_frm || (sum >= best_dist_q);
`else
        end_class = last_frm;
`endif
    end

    always_comb begin
        state_d      = state_q;
        qbuf_d       = qbuf_q;
        load_cnt_d   = load_cnt_q;
        frm_d        = frm_q;
        cls_d        = cls_q;
        acc_d        = acc_q;
        best_dist_d  = best_dist_q;
        best_class_d = best_class_q;
        case (state_q)
            S_LOAD: begin
                if (query_valid) begin
                    for (int i = 0; i < N_FRAMES; i++) begin
                        if (load_cnt_q == FRAME_IDX_W'(i)) qbuf_d[i] = query_data;
                    end
                    if (load_cnt_q == LAST_FRM) begin
                        state_d      = S_SEARCH;
                        load_cnt_d   = '0;
                        cls_d        = '0;
                        frm_d        = '0;
                        acc_d        = '0;
                        best_dist_d  = '1;
                        best_class_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            S_SEARCH: begin
                // Strict compare keeps the lower class index on ties.
                if (last_frm && (sum < best_dist_q)) begin
                    best_dist_d  = sum;
                    best_class_d = cls_q;
                end
                if (end_class) begin
                    acc_d = '0;
                    frm_d = '0;
                    if (cls_q == LAST_CLS) state_d = S_DONE;
                    else                   cls_d   = cls_q + 1'b1;
                end else begin
                    acc_d = sum;
                    frm_d = frm_q + 1'b1;
                end
            end
            S_DONE: begin
                if (result_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            load_cnt_q   <= '0;
            frm_q        <= '0;
            cls_q        <= '0;
            acc_q        <= '0;
            best_dist_q  <= '0;
            best_class_q <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            frm_q        <= frm_d;
            cls_q        <= cls_d;
            acc_q        <= acc_d;
            best_dist_q  <= best_dist_d;
            best_class_q <= best_class_d;
        end
    end

    // Query buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        qbuf_q <= qbuf_d;
    end

    assign query_ready  = (state_q == S_LOAD);
    assign busy         = (state_q == S_SEARCH) || (state_q == S_DONE);
    assign result_valid = (state_q == S_DONE);
    assign result_class = (state_q == S_DONE) ? best_class_q : '0;
    assign result_dist  = (state_q == S_DONE) ? best_dist_q  : '0;
    assign frame_id     = (state_q == S_SEARCH) ? cls_q : '0;
    assign frame_index  = (state_q == S_SEARCH) ? frm_q : '0;

endmodule

// File: tb/tb_class_hvec_search.sv
// Directed bench for class_hvec_search with a behavioural class memory and a popcount/cycle model.
module tb_class_hvec_search;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        query_valid;
    logic        query_ready;
    logic [63:0] query_data;
    logic [2:0]  frame_id;
    logic [1:0]  frame_index;
    logic [63:0] class_vec_in;
    logic        result_valid;
    logic        result_ready;
    logic [2:0]  result_class;
    logic [7:0]  result_dist;
    logic        busy;

    logic [63:0] mem [8][3];
    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    class_hvec_search dut (
        .clk(clk), .rst_n(rst_n),
        .query_valid(query_valid), .query_ready(query_ready), .query_data(query_data),
        .frame_id(frame_id), .frame_index(frame_index), .class_vec_in(class_vec_in),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_dist(result_dist), .busy(busy)
    );

    assign class_vec_in = (frame_index < 2'd3) ? mem[frame_id][frame_index] : 64'h0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic set_mem(input bit dup26);
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 3; f++) begin
                int cc;
                cc = (dup26 && c == 6) ? 2 : c;
                mem[c][f] = {32'(cc * 32'h9E3779B9 + f * 32'h7F4A7C15 + 32'h01234567),
                             32'(((cc + 1) * 32'h85EBCA6B) ^ ((f + 3) * 32'hC2B2AE35))};
            end
        end
    endtask

    task automatic model(input logic [63:0] q0, q1, q2, output int cyc);
        logic [63:0] q [3];
        int best;
        q[0] = q0; q[1] = q1; q[2] = q2;
        best = 255;
        cyc  = 0;
        for (int c = 0; c < 8; c++) begin
            int acc;
            acc = 0;
            for (int f = 0; f < 3; f++) begin
                int sum;
                cyc++;
                sum = acc + $countones(q[f] ^ mem[c][f]);
                if (f == 2) begin
                    if (sum < best) best = sum;
                end
`ifdef CLASS_HVEC_SEARCH_EARLY_EXIT_EN
                else if (sum >= best) break;
`endif
                else acc = sum;
            end
        end
    endtask

    task automatic send_query(input logic [63:0] q0, q1, q2);
        logic [63:0] q [3];
        q[0] = q0; q[1] = q1; q[2] = q2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("load_ready", {63'h0, query_ready}, 64'd1);
            query_valid = 1'b1;
            query_data  = q[i];
            @(posedge clk);
        end
        #1 query_valid = 1'b0;
    endtask

    task automatic search_and_check(input logic [63:0] q0, q1, q2, input int hand_cls,
                                    input int hand_dist, input int abort_at, input bit hold);
        int m_cyc;
        int cyc;
        logic [2:0] held_cls;
        logic [7:0] held_dist;
        model(q0, q1, q2, m_cyc);
        send_query(q0, q1, q2);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (result_valid) break;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_qrdy", {63'h0, query_ready}, 64'd1);
                chk("abort_busy", {63'h0, busy}, 64'd0);
                chk("abort_rv", {63'h0, result_valid}, 64'd0);
                chk("abort_fid", {61'h0, frame_id}, 64'd0);
                chk("abort_fidx", {62'h0, frame_index}, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_no_result", {63'h0, result_valid}, 64'd0);
                end
                return;
            end
`ifndef CLASS_HVEC_SEARCH_EARLY_EXIT_EN
            chk("seq_id", {61'h0, frame_id}, 64'(cyc / 3));
            chk("seq_idx", {62'h0, frame_index}, 64'(cyc % 3));
`endif
            chk("search_qrdy", {63'h0, query_ready}, 64'd0);
            query_valid = (cyc == 5);
            query_data  = 64'hDEAD_BEEF_0BAD_F00D;
            cyc++;
            if (cyc > 100) begin
                chk("search_timeout", 64'(cyc), 64'(m_cyc));
                return;
            end
        end
        query_valid = 1'b0;
        chk("cycles", 64'(cyc), 64'(m_cyc));
        chk("res_cls", {61'h0, result_class}, 64'(hand_cls));
        chk("res_dist", {56'h0, result_dist}, 64'(hand_dist));
        chk("done_busy", {63'h0, busy}, 64'd1);
        chk("done_fid", {61'h0, frame_id}, 64'd0);
        if (hold) begin
            held_cls  = result_class;
            held_dist = result_dist;
            for (int i = 0; i < 10; i++) begin
                query_valid = (i == 3);
                query_data  = 64'hFFFF_0000_FFFF_0000;
                @(negedge clk);
                chk("hold_rv", {63'h0, result_valid}, 64'd1);
                chk("hold_cls", {61'h0, result_class}, 64'(hand_cls));
                chk("hold_dist", {56'h0, result_dist}, {56'h0, held_dist});
                chk("hold_qrdy", {63'h0, query_ready}, 64'd0);
            end
            chk("hold_cls_stable", {61'h0, result_class}, {61'h0, held_cls});
            query_valid  = 1'b0;
            result_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("post_rv", {63'h0, result_valid}, 64'd0);
        chk("post_qrdy", {63'h0, query_ready}, 64'd1);
        chk("post_busy", {63'h0, busy}, 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        query_valid  = 1'b0;
        query_data   = '0;
        result_ready = 1'b1;
        set_mem(1'b0);
        #3;
        chk("rst_qrdy", {63'h0, query_ready}, 64'd1);
        chk("rst_rv", {63'h0, result_valid}, 64'd0);
        chk("rst_cls", {61'h0, result_class}, 64'd0);
        chk("rst_dist", {56'h0, result_dist}, 64'd0);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_fid", {61'h0, frame_id}, 64'd0);
        chk("rst_fidx", {62'h0, frame_index}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        search_and_check(mem[3][0], mem[3][1], mem[3][2], 3, 0, -1, 1'b0);
        search_and_check(mem[5][0], mem[5][1] ^ 64'h0000_0100_0020_8001, mem[5][2], 5, 4, -1, 1'b0);

        set_mem(1'b1);
        search_and_check(mem[2][0], mem[2][1], mem[2][2], 2, 0, -1, 1'b0);

        set_mem(1'b0);
        result_ready = 1'b0;
        search_and_check(mem[1][0], mem[1][1], mem[1][2], 1, 0, -1, 1'b1);

        search_and_check(mem[4][0], mem[4][1], mem[4][2], 4, 0, 11, 1'b0);
        search_and_check(mem[7][0], mem[7][1], mem[7][2], 7, 0, -1, 1'b0);

        search_and_check(mem[0][0], mem[0][1], mem[0][2], 0, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
